// File: rtl/quad_decoder.sv
// Quadrature encoder front end: per-phase synchronizer and glitch filter,
// 4x quadrature decode into step/dir pulses, a loadable wrapping position
// counter and a sticky illegal-transition flag.
module quad_decoder #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             qa,
  input  logic             qb,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             clear_err,
  output logic             step,
  output logic             dir,
  output logic [WIDTH-1:0] position,
  output logic             err
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  // Cycles the baseline keeps following the filtered phases after reset, so
  // an encoder resting at a non-00 position has fully propagated through the
  // synchronizer and filter before transitions are judged.
  localparam int ARM_CYCLES = SYNC_STAGES + FILTER_LEN + 1;
  localparam int ACW        = $clog2(ARM_CYCLES + 1);

  typedef enum logic {UNARMED = 1'b0, TRACK = 1'b1} state_t;

  logic [1:0]       raw_s;
  logic [1:0]       ab_s;
  logic [1:0]       cur_pos_s;
  logic [1:0]       prev_pos_s;
  logic [1:0]       delta_s;
  logic             fwd_s;
  logic             rev_s;
  logic             ill_s;

  state_t           state_r;
  logic [ACW-1:0]   arm_cnt_r;
  logic [1:0]       prev_ab_r;
  logic             step_r;
  logic             dir_r;
  logic [WIDTH-1:0] position_r;
  logic             err_r;

  assign raw_s = {qa, qb};

  genvar p;
  for (p = 0; p < 2; p++) begin : g_phase
    logic [SYNC_STAGES-1:0] sync_r;
    logic [CW-1:0]          cnt_r;
    logic                   filt_r;

    // Synchronize the phase, then accept a new level only after it has
    // differed from the filtered value for FILTER_LEN consecutive samples.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync_r <= '0;
        cnt_r  <= '0;
        filt_r <= 1'b0;
      end else begin
        sync_r <= {sync_r[SYNC_STAGES-2:0], raw_s[p]};
        if (sync_r[SYNC_STAGES-1] == filt_r) begin
          cnt_r <= '0;
        end else if (cnt_r == CW'(FILTER_LEN - 1)) begin
          filt_r <= sync_r[SYNC_STAGES-1];
          cnt_r  <= '0;
        end else begin
          cnt_r <= cnt_r + CW'(1'b1);
        end
      end
    end

    assign ab_s[p] = filt_r;
  end

  // Map Gray-coded AB onto a 0..3 ring position; the modular difference
  // gives 1 for forward, 3 for reverse and 2 for a two-bit jump.
  assign cur_pos_s  = {ab_s[1], ab_s[1] ^ ab_s[0]};
  assign prev_pos_s = {prev_ab_r[1], prev_ab_r[1] ^ prev_ab_r[0]};
  assign delta_s    = cur_pos_s - prev_pos_s;

  // Classify the transition between previous and current filtered AB.
  always_comb begin
    fwd_s = 1'b0;
    rev_s = 1'b0;
    ill_s = 1'b0;
    case (delta_s)
      2'd1:    fwd_s = 1'b1;
      2'd3:    rev_s = 1'b1;
      2'd2:    ill_s = 1'b1;
      default: begin
        fwd_s = 1'b0;
        rev_s = 1'b0;
        ill_s = 1'b0;
      end
    endcase
  end

  // Arm/track FSM with registered step, dir, position and err.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= UNARMED;
      arm_cnt_r  <= '0;
      prev_ab_r  <= 2'b00;
      step_r     <= 1'b0;
      dir_r      <= 1'b1;
      position_r <= '0;
      err_r      <= 1'b0;
    end else begin
      prev_ab_r <= ab_s;
      case (state_r)
        UNARMED: begin
          step_r <= 1'b0;
          if (arm_cnt_r == ACW'(ARM_CYCLES - 1)) begin
            state_r <= TRACK;
          end else begin
            arm_cnt_r <= arm_cnt_r + ACW'(1'b1);
          end
          if (load) begin
            position_r <= load_data;
          end
          if (clear_err) begin
            err_r <= 1'b0;
          end
        end
        TRACK: begin
          step_r <= fwd_s | rev_s;
          if (fwd_s) begin
            dir_r <= 1'b1;
          end else if (rev_s) begin
            dir_r <= 1'b0;
          end
          if (load) begin
            position_r <= load_data;
          end else if (fwd_s) begin
            position_r <= position_r + WIDTH'(1'b1);
          end else if (rev_s) begin
            position_r <= position_r - WIDTH'(1'b1);
          end
          if (ill_s) begin
            err_r <= 1'b1;
          end else if (clear_err) begin
            err_r <= 1'b0;
          end
        end
        default: begin
          state_r <= UNARMED;
          step_r  <= 1'b0;
        end
      endcase
    end
  end

  assign step     = step_r;
  assign dir      = dir_r;
  assign position = position_r;
  assign err      = err_r;

endmodule
